// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - parallel-in / serial-out handshake bundle for shift_seq_ctrl
interface shift_seq_ctrl_if #(
  parameter int N = 8
);
  logic [N-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         msb_first;
  logic         shift_en;
  logic         s_out;
  logic         busy;
  logic         done_tick;

  modport master (
    output din, din_valid, msb_first, shift_en,
    input  din_ready, s_out, busy, done_tick
  );

  modport slave (
    input  din, din_valid, msb_first, shift_en,
    output din_ready, s_out, busy, done_tick
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - serial shift-out sequencer, one bit per shift_en strobe
// Optional trailing even-parity bit enabled by defining SHIFT_SEQ_PARITY_EN.
module shift_seq_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic              clk,
  input  logic              reset,
  shift_seq_ctrl_if.slave   bus
);

`ifdef SHIFT_SEQ_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t         state, next_state;
  logic [N-1:0]   sreg;
  logic [CW-1:0]  count;
  logic           order;
  logic           load;
  logic           shift;
`ifdef SHIFT_SEQ_PARITY_EN
  logic           par_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      count <= '0;
      order <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (load) begin
        sreg  <= bus.din;
        order <= bus.msb_first;
        count <= '0;
`ifdef SHIFT_SEQ_PARITY_EN
        // Parity is latched at capture because the shift register drains to zero.
        par_bit <= ^bus.din;
`endif
      end else if (shift) begin
        sreg  <= order ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};
        count <= count + CW'(1);
      end
    end
  end

  always_comb begin
    next_state    = state;
    load          = 1'b0;
    shift         = 1'b0;
    bus.din_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.s_out     = 1'b1;
    bus.done_tick = 1'b0;
    case (state)
      IDLE: begin
        bus.din_ready = 1'b1;
        if (bus.din_valid) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        bus.busy  = 1'b1;
        bus.s_out = order ? sreg[N-1] : sreg[0];
        if (bus.shift_en) begin
          if (count == CW'(N-1)) begin
`ifdef SHIFT_SEQ_PARITY_EN
            next_state = PAR;
`else
            bus.done_tick = 1'b1;
            next_state    = IDLE;
`endif
          end else begin
            shift = 1'b1;
          end
        end
      end
`ifdef SHIFT_SEQ_PARITY_EN
      PAR: begin
        bus.busy  = 1'b1;
        bus.s_out = par_bit;
        if (bus.shift_en) begin
          bus.done_tick = 1'b1;
          next_state    = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed table-driven bench for shift_seq_ctrl
module tb_shift_seq_ctrl;
  localparam int N = 8;
`ifdef SHIFT_SEQ_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  shift_seq_ctrl_if #(.N(N)) bus ();
  shift_seq_ctrl #(.N(N), .CW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // seq lists the transmitted data bits left to right (first bit in [7]).
  typedef struct {
    logic [7:0] din;
    logic       msb;
    int         period;
    logic [7:0] seq;
    logic       par;
    logic       distract;
    int         stall_bit;
    int         stall_len;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_word(input vec_t v, input int idx);
    int   busy_cycles;
    int   exp_busy;
    logic eb;
    logic held;
    busy_cycles = 0;
    exp_busy = NB * v.period + ((v.stall_bit >= 0) ? v.stall_len : 0);
    check($sformatf("v%0d ready_idle", idx), bus.din_ready, 1);
    bus.din = v.din;
    bus.msb_first = v.msb;
    bus.din_valid = 1'b1;
    bus.shift_en = 1'b0;
    step();
    if (v.distract) bus.din = 8'h5A;
    else bus.din_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      eb = (i < N) ? v.seq[N-1-i] : v.par;
      if (i == v.stall_bit) begin
        held = bus.s_out;
        for (int s = 0; s < v.stall_len; s++) begin
          bus.shift_en = 1'b0;
          #1;
          if (bus.busy) busy_cycles++;
          check($sformatf("v%0d stall s_out", idx), bus.s_out, held);
          step();
        end
      end
      for (int c = 0; c < v.period; c++) begin
        bus.shift_en = (c == v.period - 1);
        #1;
        if (bus.busy) busy_cycles++;
        check($sformatf("v%0d bit%0d s_out", idx, i), bus.s_out, eb);
        check($sformatf("v%0d bit%0d ready", idx, i), bus.din_ready, 0);
        check($sformatf("v%0d bit%0d done", idx, i), bus.done_tick,
              (i == NB - 1 && c == v.period - 1) ? 1 : 0);
        step();
      end
    end
    bus.shift_en = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    check($sformatf("v%0d busy_after", idx), bus.busy, 0);
    check($sformatf("v%0d s_out_after", idx), bus.s_out, 1);
    check($sformatf("v%0d ready_after", idx), bus.din_ready, 1);
    check($sformatf("v%0d done_after", idx), bus.done_tick, 0);
    check($sformatf("v%0d busy_cycles", idx), busy_cycles, exp_busy);
  endtask

  initial begin
    int dones;
    vecs[0] = '{din: 8'hC1, msb: 1'b0, period: 4, seq: 8'b1000_0011, par: 1'b1, distract: 1'b0, stall_bit: -1, stall_len: 0};
    vecs[1] = '{din: 8'hC1, msb: 1'b1, period: 1, seq: 8'b1100_0001, par: 1'b1, distract: 1'b0, stall_bit: -1, stall_len: 0};
    vecs[2] = '{din: 8'hC1, msb: 1'b0, period: 2, seq: 8'b1000_0011, par: 1'b1, distract: 1'b1, stall_bit: -1, stall_len: 0};
    vecs[3] = '{din: 8'h5A, msb: 1'b0, period: 1, seq: 8'b0101_1010, par: 1'b0, distract: 1'b0, stall_bit: -1, stall_len: 0};
    vecs[4] = '{din: 8'hA5, msb: 1'b1, period: 3, seq: 8'b1010_0101, par: 1'b0, distract: 1'b0, stall_bit: 3, stall_len: 100};
    vecs[5] = '{din: 8'h03, msb: 1'b0, period: 1, seq: 8'b1100_0000, par: 1'b0, distract: 1'b0, stall_bit: -1, stall_len: 0};

    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.msb_first = 1'b0;
    bus.shift_en = 1'b0;
    step();
    step();
    check("reset s_out", bus.s_out, 1);
    check("reset busy", bus.busy, 0);
    check("reset ready", bus.din_ready, 1);
    check("reset done", bus.done_tick, 0);
    reset = 1'b0;
    step();

    // shift_en in IDLE must not start anything
    bus.shift_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("idle_strobe busy", bus.busy, 0);
      check("idle_strobe s_out", bus.s_out, 1);
      step();
    end
    bus.shift_en = 1'b0;

    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v], v);
      step();
    end

    // Abort 8'hFF after its third strobe; reset acts within the cycle
    bus.din = 8'hFF;
    bus.msb_first = 1'b0;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    bus.shift_en = 1'b1;
    for (int c = 0; c < 3; c++) step();
    #1;
    check("abort pre s_out", bus.s_out, 1);
    check("abort pre busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("abort s_out", bus.s_out, 1);
    check("abort busy", bus.busy, 0);
    check("abort ready", bus.din_ready, 1);
    check("abort done", bus.done_tick, 0);
    step();
    step();
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.done_tick) dones++;
      step();
    end
    bus.shift_en = 1'b0;
    check("abort no_done", dones, 0);
    send_word('{din: 8'h01, msb: 1'b0, period: 1, seq: 8'b1000_0000, par: 1'b1,
                distract: 1'b0, stall_bit: -1, stall_len: 0}, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
